// File: rtl/uvme_obi_st_slv_rsp.sv
// -----------------------------------------------------------------------------
// uvme_obi_st_slv_rsp
//
// OBI responder (slave) for the OBI self-test environment. It grants
// address-phase requests and applies writes to an internal word memory. Reads
// sample that memory. Every accepted transaction produces one entry in a
// circular response FIFO, and responses go back in order on the R channel
// after RSP_LATENCY cycles. Accesses below BASE_ADDR or beyond MEM_DEPTH words
// return an error response and leave the memory untouched.
//
// Optional feature macro: UVME_OBI_ST_SLV_RSP_RREADY_EN
//   defined   : the rready port exists and back-pressures the R channel.
//   undefined : there is no rready port. Every response is valid for exactly
//               one cycle.
//
// Ports
//   clk      in   clock, rising edge
//   reset_n  in   synchronous reset, active-low
//   req      in   address-phase request
//   gnt      out  address-phase grant (combinational from req)
//   addr     in   byte address
//   we       in   1 = write, 0 = read
//   be       in   byte enables (writes only)
//   wdata    in   write data
//   aid      in   request ID
//   rvalid   out  response valid
//   rready   in   response ready (only with UVME_OBI_ST_SLV_RSP_RREADY_EN)
//   rdata    out  read data; 0 for writes and errors
//   err      out  error response
//   rid      out  response ID
// -----------------------------------------------------------------------------
module uvme_obi_st_slv_rsp #(
   parameter int unsigned           ADDR_WIDTH      = 32,
   parameter int unsigned           DATA_WIDTH      = 32,
   parameter int unsigned           ID_WIDTH        = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
   parameter int unsigned           MEM_DEPTH       = 256,
   parameter int unsigned           MAX_OUTSTANDING = 4,
   parameter int unsigned           RSP_LATENCY     = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    req,
   output logic                    gnt,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [ID_WIDTH-1:0]     aid,
   output logic                    rvalid,
`ifdef UVME_OBI_ST_SLV_RSP_RREADY_EN
   input  logic                    rready,
`endif
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    err,
   output logic [ID_WIDTH-1:0]     rid
);

   localparam int unsigned BE_W  = DATA_WIDTH / 8;
   localparam int unsigned OFF_W = $clog2(BE_W);
   localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned LAT_W = 4;

   localparam logic [LAT_W-1:0]      LAT_INIT = LAT_W'(RSP_LATENCY - 1);
   localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(MEM_DEPTH);

   // ---------------------------------------------------------------------------
   // Pointer increment with wrap at MAX_OUTSTANDING. The depth does not need to
   // be a power of 2.
   // ---------------------------------------------------------------------------
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_LAST) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   // ---------------------------------------------------------------------------
   // Declarations
   // ---------------------------------------------------------------------------
   logic                  rready_int;

   logic [ADDR_WIDTH-1:0] addr_off;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic                  in_range;
   logic [IDX_W-1:0]      mem_idx;
   logic [DATA_WIDTH-1:0] rd_word;

   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] push_rdata;
   logic                  push_err;

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   logic [DATA_WIDTH-1:0] fifo_rdata_q [MAX_OUTSTANDING];
   logic [DATA_WIDTH-1:0] fifo_rdata_d [MAX_OUTSTANDING];
   logic                  fifo_err_q   [MAX_OUTSTANDING];
   logic                  fifo_err_d   [MAX_OUTSTANDING];
   logic [ID_WIDTH-1:0]   fifo_rid_q   [MAX_OUTSTANDING];
   logic [ID_WIDTH-1:0]   fifo_rid_d   [MAX_OUTSTANDING];
   logic [LAT_W-1:0]      fifo_cnt_q   [MAX_OUTSTANDING];
   logic [LAT_W-1:0]      fifo_cnt_d   [MAX_OUTSTANDING];

   logic [PTR_W-1:0]      wptr_q, wptr_d;
   logic [PTR_W-1:0]      rptr_q, rptr_d;
   logic [CNT_W-1:0]      count_q, count_d;

`ifdef UVME_OBI_ST_SLV_RSP_RREADY_EN
   assign rready_int = rready;
`else
   assign rready_int = 1'b1;
`endif

   // ---------------------------------------------------------------------------
   // Address decode. The byte-offset bits drop out in the shift. The range test
   // uses the full-width word index, so addresses far past the memory cannot
   // alias back into it.
   // ---------------------------------------------------------------------------
   assign addr_off = addr - BASE_ADDR;
   assign word_idx = addr_off >> OFF_W;
   assign in_range = (addr >= BASE_ADDR) && (word_idx < DEPTH_A);
   assign mem_idx  = word_idx[IDX_W-1:0];
   assign rd_word  = mem_q[mem_idx];

   // ---------------------------------------------------------------------------
   // Handshakes. gnt uses the registered count, so a pop in the same cycle does
   // not open a slot until the next cycle.
   // ---------------------------------------------------------------------------
   assign gnt    = req && (count_q < CNT_MAX) && reset_n;
   assign push   = req && gnt;
   assign rvalid = (count_q != '0) && (fifo_cnt_q[rptr_q] == '0);
   assign pop    = rvalid && rready_int;

   assign rdata  = fifo_rdata_q[rptr_q];
   assign err    = fifo_err_q[rptr_q];
   assign rid    = fifo_rid_q[rptr_q];

   assign push_err   = !in_range;
   assign push_rdata = (in_range && !we) ? rd_word : '0;

   // ---------------------------------------------------------------------------
   // Word memory. Only in-range accepted writes modify it, lane by lane.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(MEM_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (push && we && in_range) begin
         for (int b = 0; b < int'(BE_W); b++) begin
            if (be[b]) begin
               mem_q[mem_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Response FIFO next state. Every live latency counter runs down in
   // parallel, whatever its position. A newer entry can therefore be ready as
   // soon as it reaches the head. The push slot is never the live head: a push
   // needs gnt, and gnt is low when the FIFO is full.
   // ---------------------------------------------------------------------------
   always_comb begin
      fifo_rdata_d = fifo_rdata_q;
      fifo_err_d   = fifo_err_q;
      fifo_rid_d   = fifo_rid_q;
      fifo_cnt_d   = fifo_cnt_q;
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      count_d      = count_q;

      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
         if (fifo_cnt_q[i] != '0) begin
            fifo_cnt_d[i] = fifo_cnt_q[i] - 1'b1;
         end
      end

      if (push) begin
         fifo_rdata_d[wptr_q] = push_rdata;
         fifo_err_d[wptr_q]   = push_err;
         fifo_rid_d[wptr_q]   = aid;
         fifo_cnt_d[wptr_q]   = LAT_INIT;
         wptr_d               = ptr_inc(wptr_q);
      end

      if (pop) begin
         rptr_d = ptr_inc(rptr_q);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FIFO state registers. Reset clears the payload too, so the R outputs read
   // 0 after reset and no stale response can reappear.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            fifo_rdata_q[i] <= '0;
            fifo_err_q[i]   <= 1'b0;
            fifo_rid_q[i]   <= '0;
            fifo_cnt_q[i]   <= '0;
         end
      end else begin
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         count_q      <= count_d;
         fifo_rdata_q <= fifo_rdata_d;
         fifo_err_q   <= fifo_err_d;
         fifo_rid_q   <= fifo_rid_d;
         fifo_cnt_q   <= fifo_cnt_d;
      end
   end

endmodule

// File: tb/tb_uvme_obi_st_slv_rsp.sv
// -----------------------------------------------------------------------------
// Testbench for uvme_obi_st_slv_rsp.
// Instance A uses RSP_LATENCY=1 and runs a table of per-cycle vectors followed
// by a back-to-back read burst. Instance B uses RSP_LATENCY=3 and covers
// latency, full/back-pressure (or sustained throughput without rready), and
// reset with responses still outstanding.
// -----------------------------------------------------------------------------
module tb_uvme_obi_st_slv_rsp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Instance A signals
   logic        a_rst_n, a_req, a_we, a_gnt, a_rvalid, a_err;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic [3:0]  a_be, a_aid, a_rid;
   // Instance B signals
   logic        b_rst_n, b_req, b_we, b_gnt, b_rvalid, b_err;
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic [3:0]  b_be, b_aid, b_rid;
`ifdef UVME_OBI_ST_SLV_RSP_RREADY_EN
   logic        a_rready, b_rready;
`endif

   uvme_obi_st_slv_rsp #(.RSP_LATENCY(1), .MAX_OUTSTANDING(4)) u_a (
      .clk(clk), .reset_n(a_rst_n), .req(a_req), .gnt(a_gnt), .addr(a_addr),
      .we(a_we), .be(a_be), .wdata(a_wdata), .aid(a_aid), .rvalid(a_rvalid),
`ifdef UVME_OBI_ST_SLV_RSP_RREADY_EN
      .rready(a_rready),
`endif
      .rdata(a_rdata), .err(a_err), .rid(a_rid)
   );

   uvme_obi_st_slv_rsp #(.RSP_LATENCY(3), .MAX_OUTSTANDING(4)) u_b (
      .clk(clk), .reset_n(b_rst_n), .req(b_req), .gnt(b_gnt), .addr(b_addr),
      .we(b_we), .be(b_be), .wdata(b_wdata), .aid(b_aid), .rvalid(b_rvalid),
`ifdef UVME_OBI_ST_SLV_RSP_RREADY_EN
      .rready(b_rready),
`endif
      .rdata(b_rdata), .err(b_err), .rid(b_rid)
   );

   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [3:0]  aid;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        err;
      logic [3:0]  rid;
   } vec_t;

   localparam int NV = 15;
   vec_t vt [NV];

   function automatic vec_t mk(input logic r, input logic w, input logic [31:0] ad,
                               input logic [3:0] b, input logic [31:0] wd, input logic [3:0] id,
                               input logic g, input logic v, input logic [31:0] rd,
                               input logic e, input logic [3:0] ri);
      vec_t x;
      x.req = r; x.we = w; x.addr = ad; x.be = b; x.wdata = wd; x.aid = id;
      x.gnt = g; x.rvalid = v; x.rdata = rd; x.err = e; x.rid = ri;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle on instance A: drive after the falling edge, sample 1 ns later.
   task automatic a_cyc(input logic r, input logic w, input logic [31:0] ad,
                        input logic [3:0] b, input logic [31:0] wd, input logic [3:0] id);
      @(negedge clk);
      a_req = r; a_we = w; a_addr = ad; a_be = b; a_wdata = wd; a_aid = id;
      #1;
   endtask

   task automatic b_cyc(input logic r, input logic w, input logic [31:0] ad,
                        input logic [3:0] b, input logic [31:0] wd, input logic [3:0] id);
      @(negedge clk);
      b_req = r; b_we = w; b_addr = ad; b_be = b; b_wdata = wd; b_aid = id;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Each row gives the inputs for one cycle and the outputs expected in
      // that same cycle. With latency 1, a row's response shows in the next row.
      //           req we addr        be    wdata         aid   gnt rv rdata         err rid
      vt[0]  = mk(1, 1, 32'h10,  4'hF, 32'hDEADBEEF, 4'd3,  1, 0, 32'h0,        0, 4'd0);
      vt[1]  = mk(1, 0, 32'h10,  4'h0, 32'h0,        4'd5,  1, 1, 32'h0,        0, 4'd3);
      vt[2]  = mk(1, 1, 32'h20,  4'hF, 32'hAABBCCDD, 4'd1,  1, 1, 32'hDEADBEEF, 0, 4'd5);
      vt[3]  = mk(1, 1, 32'h20,  4'h5, 32'h11223344, 4'd2,  1, 1, 32'h0,        0, 4'd1);
      vt[4]  = mk(1, 0, 32'h20,  4'h0, 32'h0,        4'd4,  1, 1, 32'h0,        0, 4'd2);
      vt[5]  = mk(1, 0, 32'h400, 4'hF, 32'h0,        4'd6,  1, 1, 32'hAA22CC44, 0, 4'd4);
      vt[6]  = mk(1, 1, 32'h404, 4'hF, 32'hFFFFFFFF, 4'd7,  1, 1, 32'h0,        1, 4'd6);
      vt[7]  = mk(1, 0, 32'h22,  4'h0, 32'h0,        4'd8,  1, 1, 32'h0,        1, 4'd7);
      vt[8]  = mk(1, 1, 32'h24,  4'h0, 32'h12345678, 4'd9,  1, 1, 32'hAA22CC44, 0, 4'd8);
      vt[9]  = mk(1, 0, 32'h24,  4'hF, 32'h0,        4'hA,  1, 1, 32'h0,        0, 4'd9);
      vt[10] = mk(1, 0, 32'h4,   4'h0, 32'h0,        4'hC,  1, 1, 32'h0,        0, 4'hA);
      vt[11] = mk(1, 1, 32'h3FC, 4'hF, 32'hCAFEF00D, 4'hD,  1, 1, 32'h0,        0, 4'hC);
      vt[12] = mk(1, 0, 32'h3FC, 4'h0, 32'h0,        4'hE,  1, 1, 32'h0,        0, 4'hD);
      vt[13] = mk(0, 0, 32'h0,   4'h0, 32'h0,        4'h0,  0, 1, 32'hCAFEF00D, 0, 4'hE);
      vt[14] = mk(0, 0, 32'h0,   4'h0, 32'h0,        4'h0,  0, 0, 32'h0,        0, 4'h0);

      a_rst_n = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_be = '0; a_wdata = '0; a_aid = '0;
      b_rst_n = 1'b0; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_be = '0; b_wdata = '0; b_aid = '0;
`ifdef UVME_OBI_ST_SLV_RSP_RREADY_EN
      a_rready = 1'b1; b_rready = 1'b1;
`endif

      // Reset: gnt is forced low, and all outputs are 0 after a reset edge
      @(negedge clk);
      a_req = 1'b1; b_req = 1'b1;
      #1;
      chk("rst gnt A", 32'(a_gnt), 32'd0);
      chk("rst gnt B", 32'(b_gnt), 32'd0);
      @(negedge clk);
      #1;
      chk("rst rvalid A", 32'(a_rvalid), 32'd0);
      chk("rst rdata A", a_rdata, 32'd0);
      chk("rst err A", 32'(a_err), 32'd0);
      chk("rst rid A", 32'(a_rid), 32'd0);
      chk("rst rvalid B", 32'(b_rvalid), 32'd0);
      chk("rst rdata B", b_rdata, 32'd0);
      chk("rst err B", 32'(b_err), 32'd0);
      chk("rst rid B", 32'(b_rid), 32'd0);
      a_req = 1'b0; b_req = 1'b0;
      a_rst_n = 1'b1; b_rst_n = 1'b1;

      // Table-driven vectors on instance A
      for (int i = 0; i < NV; i++) begin
         a_cyc(vt[i].req, vt[i].we, vt[i].addr, vt[i].be, vt[i].wdata, vt[i].aid);
         chk($sformatf("row%0d gnt", i), 32'(a_gnt), 32'(vt[i].gnt));
         chk($sformatf("row%0d rvalid", i), 32'(a_rvalid), 32'(vt[i].rvalid));
         if (vt[i].rvalid) begin
            chk($sformatf("row%0d rdata", i), a_rdata, vt[i].rdata);
            chk($sformatf("row%0d err", i), 32'(a_err), 32'(vt[i].err));
            chk($sformatf("row%0d rid", i), 32'(a_rid), 32'(vt[i].rid));
         end
      end

      // Back-to-back reads of 8 words: a grant every cycle, and the responses
      // follow one cycle later in ID order. Word 4 (0x10) holds DEADBEEF.
      for (int i = 0; i <= 9; i++) begin
         if (i < 8) a_cyc(1'b1, 1'b0, 32'(i * 4), 4'hF, 32'h0, 4'(i));
         else       a_cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
         chk($sformatf("b2b%0d gnt", i), 32'(a_gnt), (i < 8) ? 32'd1 : 32'd0);
         chk($sformatf("b2b%0d rvalid", i), 32'(a_rvalid), (i >= 1 && i <= 8) ? 32'd1 : 32'd0);
         if (i >= 1 && i <= 8) begin
            chk($sformatf("b2b%0d rid", i), 32'(a_rid), 32'(i - 1));
            chk($sformatf("b2b%0d rdata", i), a_rdata, (i - 1 == 4) ? 32'hDEADBEEF : 32'h0);
         end
      end

      // Instance B: a write, then rvalid exactly three cycles after acceptance
      b_cyc(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 4'd1);
      chk("lat3 gnt", 32'(b_gnt), 32'd1);
      for (int c = 1; c <= 4; c++) begin
         b_cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
         chk($sformatf("lat3 c%0d rvalid", c), 32'(b_rvalid), (c == 3) ? 32'd1 : 32'd0);
         if (c == 3) chk("lat3 rid", 32'(b_rid), 32'd1);
      end

`ifdef UVME_OBI_ST_SLV_RSP_RREADY_EN
      // Back-pressure: four grants, then full. rvalid holds the first ID until
      // rready rises in cycle 6, and gnt returns in cycle 7.
      b_rready = 1'b0;
      for (int c = 0; c <= 11; c++) begin
         b_rready = (c >= 6);
         if (c <= 7) b_cyc(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 4'(c + 1));
         else        b_cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
         chk($sformatf("bp c%0d gnt", c), 32'(b_gnt), (c <= 3 || c == 7) ? 32'd1 : 32'd0);
         chk($sformatf("bp c%0d rvalid", c), 32'(b_rvalid), (c >= 3 && c <= 10) ? 32'd1 : 32'd0);
         if (c >= 3 && c <= 10) begin
            chk($sformatf("bp c%0d rid", c), 32'(b_rid),
                (c <= 6) ? 32'd1 : (c == 7) ? 32'd2 : (c == 8) ? 32'd3 : (c == 9) ? 32'd4 : 32'd8);
            chk($sformatf("bp c%0d rdata", c), b_rdata, 32'hDEADBEEF);
         end
      end
`else
      // Sustained throughput: with latency 3 and depth 4, a request held high
      // is granted every cycle, and each response is valid for exactly one cycle.
      for (int c = 0; c <= 11; c++) begin
         if (c < 8) b_cyc(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 4'(c + 1));
         else       b_cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
         chk($sformatf("tp c%0d gnt", c), 32'(b_gnt), (c < 8) ? 32'd1 : 32'd0);
         chk($sformatf("tp c%0d rvalid", c), 32'(b_rvalid), (c >= 3 && c <= 10) ? 32'd1 : 32'd0);
         if (c >= 3 && c <= 10) begin
            chk($sformatf("tp c%0d rid", c), 32'(b_rid), 32'(c - 2));
            chk($sformatf("tp c%0d rdata", c), b_rdata, 32'hDEADBEEF);
         end
      end
`endif

      // Drain, with a bounded wait
      begin
         int k;
         k = 0;
         while (b_rvalid && k < 20) begin
            b_cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
            k++;
         end
         chk("drain rvalid", 32'(b_rvalid), 32'd0);
      end

      // Reset with three reads outstanding
      for (int c = 0; c < 3; c++) begin
         b_cyc(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 4'(c + 1));
         chk($sformatf("mr c%0d gnt", c), 32'(b_gnt), 32'd1);
      end
      @(negedge clk);
      b_rst_n = 1'b0; b_req = 1'b1;
      #1;
      chk("mr gnt in reset", 32'(b_gnt), 32'd0);
      chk("mr head rvalid", 32'(b_rvalid), 32'd1);
      chk("mr head rid", 32'(b_rid), 32'd1);
      @(negedge clk);
      b_rst_n = 1'b1; b_req = 1'b0;
      #1;
      chk("mr rdata after", b_rdata, 32'd0);
      chk("mr rid after", 32'(b_rid), 32'd0);
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("mr stale%0d rvalid", c), 32'(b_rvalid), 32'd0);
         b_cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
      end
      b_cyc(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 4'd5);
      chk("mr read gnt", 32'(b_gnt), 32'd1);
      for (int c = 1; c <= 4; c++) begin
         b_cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
         chk($sformatf("mr read c%0d rvalid", c), 32'(b_rvalid), (c == 3) ? 32'd1 : 32'd0);
         if (c == 3) begin
            chk("mr read rid", 32'(b_rid), 32'd5);
            chk("mr read rdata", b_rdata, 32'd0);
            chk("mr read err", 32'(b_err), 32'd0);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
